// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and address-window helpers for the data-RAM
// arbiter.
//   word_t          : 16-bit RAM address / data word
//   REQ_CORE/REQ_DMA: requester indices (core load/store unit, loader/DMA)
//   RAM_HI          : last word of the RAM window
//   ram_lo()        : first RAM word, just above the port-mapped region
//   in_ram()        : address falls inside [ram_lo, RAM_HI]
package dram_arb_pkg;

    typedef logic [15:0] word_t;

    localparam int REQ_CORE = 0;
    localparam int REQ_DMA  = 1;

    // Bit 15 set would alias the upper half, which this RAM does not decode.
    localparam word_t RAM_HI = 16'h7FFF;

    // The port-mapped region occupies 2*2**port_exponent words from address 0.
    function automatic word_t ram_lo(input int port_exponent);
        return word_t'(2 * (2 ** port_exponent));
    endfunction

    function automatic logic in_ram(input word_t a, input int port_exponent);
        return (a >= ram_lo(port_exponent)) && (a <= RAM_HI);
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: requester-side bus of the data-RAM arbiter, one lane per
// requester (index 0 = core, 1 = DMA).
//   req/we/lock/addr/wdata : driven by the requesters
//   gnt                    : access performed this cycle
//   rvalid/err/rdata       : response for the grant of the previous cycle
//
// Handshake: req is the valid. gnt is the same-cycle ready/accept; a requester
// keeps req, we, addr and wdata stable until it sees gnt, and the access is
// complete in exactly the cycle gnt is high. Reads (and rejected accesses)
// answer with rvalid in the following cycle; in-range writes give no response.
interface dram_arbiter_if;

    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0]       lock;
    logic [1:0][15:0] addr;
    logic [1:0][15:0] wdata;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0]       err;
    logic [15:0]      rdata;

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, err, rdata
    );

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, err, rdata
    );

endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter with bounded locked bursts between the
// core (requester 0) and the loader/DMA engine (requester 1) for the shared
// single-port data RAM.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : requester bus (dram_arbiter_if.slave)
//   mem_read      : RAM read strobe for the grant cycle
//   mem_write     : RAM write strobe; the RAM commits on the falling edge
//   mem_addr      : RAM word address
//   mem_din       : RAM write data
//   mem_dout      : RAM combinational read data
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int PORT_EXPONENT = 3,
    parameter int MAX_BURST     = 4
) (
    input  logic           clk,
    input  logic           rst,
    dram_arbiter_if.slave  bus,
    output logic           mem_read,
    output logic           mem_write,
    output word_t          mem_addr,
    output word_t          mem_din,
    input  word_t          mem_dout
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    // Arbitration state
    logic       last_q;
    logic       locked_q;
    logic [3:0] burst_q;

    // Response register
    logic [1:0] rvalid_q;
    logic [1:0] err_q;
    word_t      rdata_q;

    logic       win;
    logic [1:0] win_onehot;
    logic       grant;
    logic       win_in_ram;
    logic       win_we;
    logic [3:0] burst_next;
    logic       locked_next;

    always_comb begin
        win         = 1'b0;
        win_onehot  = 2'b00;
        grant       = 1'b0;
        win_in_ram  = 1'b0;
        win_we      = 1'b0;
        burst_next  = 4'd1;
        locked_next = 1'b0;
        bus.gnt     = 2'b00;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;

        if (locked_q && bus.req[last_q]) begin
            win = last_q;
        end else if (&bus.req) begin
            win = ~last_q;
        end else begin
            // Single requester (or none, in which case win is unused).
            win = bus.req[REQ_DMA];
        end

        win_onehot[win] = 1'b1;
        grant           = (|bus.req) && !rst;
        win_in_ram      = in_ram(bus.addr[win], PORT_EXPONENT);
        win_we          = bus.we[win];

        // A burst only continues when the lock was in force and the same
        // requester wins again; any other grant opens a fresh run.
        burst_next  = (win == last_q && locked_q) ? burst_q + 4'd1 : 4'd1;
        locked_next = bus.lock[win] && (burst_next < MAX_B);

        if (grant) begin
            bus.gnt = win_onehot;
            if (win_in_ram) begin
                mem_read  = !win_we;
                mem_write = win_we;
                mem_addr  = bus.addr[win];
                mem_din   = bus.wdata[win];
            end
        end

        // Gated by rst so a read granted just before reset never answers.
        bus.rvalid = rst ? 2'b00 : rvalid_q;
        bus.err    = rst ? 2'b00 : err_q;
        bus.rdata  = rst ? '0 : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= 1'b1;
            locked_q <= 1'b0;
            burst_q  <= 4'd0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata_q  <= '0;
        end else if (grant) begin
            last_q   <= win;
            locked_q <= locked_next;
            burst_q  <= burst_next;
            if (!win_in_ram) begin
                rvalid_q <= win_onehot;
                err_q    <= win_onehot;
                rdata_q  <= '0;
            end else if (!win_we) begin
                rvalid_q <= win_onehot;
                err_q    <= 2'b00;
                rdata_q  <= mem_dout;
            end else begin
                rvalid_q <= 2'b00;
                err_q    <= 2'b00;
                rdata_q  <= '0;
            end
        end else begin
            locked_q <= 1'b0;
            burst_q  <= 4'd0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata_q  <= '0;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: table-driven directed vectors, hand-written multi-cycle
// sequences (locked burst, reset mid-burst) and a randomized run checked
// against a behavioural model of the arbitration rules and RAM contents.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int PE     = 3;
    localparam int MB     = 4;
    localparam int LO     = 2 * (1 << PE);
    localparam int W      = 20;
    localparam int N_VEC  = 16;
    localparam int N_RAND = 600;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_arbiter_if bus();
    logic  mem_read;
    logic  mem_write;
    word_t mem_addr;
    word_t mem_din;
    word_t mem_dout;

    dram_arbiter #(.PORT_EXPONENT(PE), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // RAM: combinational read, write on the falling edge.
    word_t ram [0:65535];
    assign mem_dout = ram[mem_addr];
    always @(negedge clk) if (mem_write) ram[mem_addr] <= mem_din;

    function automatic word_t ram_init(input int a);
        if (a == 16'h0100) return 16'hBEEF;
        return word_t'(a) ^ 16'h5A5A;
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] cur_bus();
        return {bus.gnt, mem_read, mem_write, mem_addr, mem_din};
    endfunction

    // rdata only carries meaning alongside rvalid.
    function automatic logic [W-1:0] mask_resp(input logic [W-1:0] r);
        return (r[19:18] != 2'b00) ? r : {r[19:16], 16'h0000};
    endfunction

    function automatic logic [W-1:0] cur_resp();
        return mask_resp({bus.rvalid, bus.err, bus.rdata});
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] w,
                         input logic [1:0] lk, input word_t a0, input word_t a1,
                         input word_t d0, input word_t d1);
        rst       = r;
        bus.req   = rq;
        bus.we    = w;
        bus.lock  = lk;
        bus.addr  = {a1, a0};
        bus.wdata = {d1, d0};
    endtask

    // Entered at posedge+1; samples at posedge+4; leaves at next posedge+1.
    task automatic check_cycle(input string name, input logic [35:0] eb, input logic [W-1:0] er);
        #3;
        check({name, "/bus"}, cur_bus(), eb);
        check({name, "/resp"}, 36'(cur_resp()), 36'(mask_resp(er)));
        @(posedge clk); #1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       rst;
        logic [1:0] req, we, lock;
        word_t      a0, a1, d0, d1;
        logic [1:0] gnt;
        logic       rd, wr;
        word_t      maddr, mdin;
        logic [1:0] rv, er;
        word_t      rdata;
    } vec_t;

    vec_t tbl [N_VEC];

    function automatic vec_t mkv(input logic r, input logic [1:0] rq, input logic [1:0] w,
                                 input logic [1:0] lk, input word_t a0, input word_t a1,
                                 input word_t d0, input word_t d1, input logic [1:0] g,
                                 input logic rd, input logic wr, input word_t ma, input word_t md,
                                 input logic [1:0] rv, input logic [1:0] er, input word_t rdt);
        vec_t v;
        v.rst = r; v.req = rq; v.we = w; v.lock = lk;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.gnt = g; v.rd = rd; v.wr = wr; v.maddr = ma; v.mdin = md;
        v.rv = rv; v.er = er; v.rdata = rdt;
        return v;
    endfunction

    // ---------------- reference model ----------------
    int    m_owner;      // requester currently holding the lock, -1 if none
    int    m_run;        // grants already taken in the owner's current run
    int    m_prev;       // most recent winner
    word_t shadow [int];

    function automatic word_t model_read(input int a);
        if (shadow.exists(a)) return shadow[a];
        return ram_init(a);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_prev  = 1;
    endtask

    task automatic model_step(output logic [35:0] eb, output logic [W-1:0] nxt);
        int w;
        int a;
        int d;
        int cnt;
        logic inr;
        logic [1:0] oh;
        eb  = '0;
        nxt = '0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner >= 0 && bus.req[m_owner]) w = m_owner;
        else if (bus.req == 2'b11) w = 1 - m_prev;
        else if (bus.req == 2'b01) w = 0;
        else if (bus.req == 2'b10) w = 1;
        else w = -1;
        if (w < 0) begin
            m_owner = -1;
            m_run   = 0;
            return;
        end
        a   = int'(bus.addr[w]);
        d   = int'(bus.wdata[w]);
        inr = (a >= LO) && (a <= 32767);
        oh  = (w == 0) ? 2'b01 : 2'b10;
        eb  = {oh, inr && !bus.we[w], inr && bus.we[w],
               inr ? word_t'(a) : 16'h0, inr ? word_t'(d) : 16'h0};
        if (!inr) nxt = {oh, oh, 16'h0000};
        else if (!bus.we[w]) nxt = {oh, 2'b00, model_read(a)};
        else shadow[a] = word_t'(d);
        cnt = (w == m_owner) ? m_run + 1 : 1;
        if (bus.lock[w] && cnt < MB) begin
            m_owner = w;
            m_run   = cnt;
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
        m_prev = w;
    endtask

    // ---------------- test ----------------
    logic [1:0] bexp [6];
    logic [1:0] prev_g;
    logic [W-1:0] er_v;

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = ram_init(a);
        drive(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors: single read, contention, write->read, range edges.
        tbl[0]  = mkv(0, 2'b01, 2'b00, 2'b00, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1, 0, 16'h0100, 16'h0000, 2'b00, 2'b00, 16'h0000);
        tbl[1]  = mkv(0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b01, 2'b00, 16'hBEEF);
        tbl[2]  = mkv(1, 2'b11, 2'b00, 2'b00, 16'h0300, 16'h0301, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0000);
        tbl[3]  = mkv(0, 2'b11, 2'b00, 2'b00, 16'h0300, 16'h0301, 16'h0000, 16'h0000, 2'b01, 1, 0, 16'h0300, 16'h0000, 2'b00, 2'b00, 16'h0000);
        tbl[4]  = mkv(0, 2'b11, 2'b00, 2'b00, 16'h0300, 16'h0301, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h0301, 16'h0000, 2'b01, 2'b00, 16'h595A);
        tbl[5]  = mkv(0, 2'b11, 2'b00, 2'b00, 16'h0300, 16'h0301, 16'h0000, 16'h0000, 2'b01, 1, 0, 16'h0300, 16'h0000, 2'b10, 2'b00, 16'h595B);
        tbl[6]  = mkv(0, 2'b11, 2'b00, 2'b00, 16'h0300, 16'h0301, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h0301, 16'h0000, 2'b01, 2'b00, 16'h595A);
        tbl[7]  = mkv(0, 2'b01, 2'b01, 2'b00, 16'h0200, 16'h0000, 16'h1234, 16'h0000, 2'b01, 0, 1, 16'h0200, 16'h1234, 2'b10, 2'b00, 16'h595B);
        tbl[8]  = mkv(0, 2'b01, 2'b00, 2'b00, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1, 0, 16'h0200, 16'h0000, 2'b00, 2'b00, 16'h0000);
        tbl[9]  = mkv(0, 2'b01, 2'b00, 2'b00, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0000, 16'h0000, 2'b01, 2'b00, 16'h1234);
        tbl[10] = mkv(0, 2'b10, 2'b10, 2'b00, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 2'b10, 0, 0, 16'h0000, 16'h0000, 2'b01, 2'b01, 16'h0000);
        tbl[11] = mkv(0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b10, 2'b10, 16'h0000);
        tbl[12] = mkv(0, 2'b01, 2'b00, 2'b00, 16'h000F, 16'h0000, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0000);
        tbl[13] = mkv(0, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1, 0, 16'h0010, 16'h0000, 2'b01, 2'b01, 16'h0000);
        tbl[14] = mkv(0, 2'b10, 2'b00, 2'b00, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h7FFF, 16'h0000, 2'b01, 2'b00, 16'h5A4A);
        tbl[15] = mkv(0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b10, 2'b00, 16'h25A5);

        for (int i = 0; i < N_VEC; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].lock,
                  tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            check_cycle($sformatf("vec%0d", i),
                        {tbl[i].gnt, tbl[i].rd, tbl[i].wr, tbl[i].maddr, tbl[i].mdin},
                        {tbl[i].rv, tbl[i].er, tbl[i].rdata});
        end
        check("oor_ram_0003", 36'(ram[16'h0003]), 36'(ram_init(16'h0003)));
        check("oor_ram_8000", 36'(ram[16'h8000]), 36'(ram_init(16'h8000)));

        // Locked burst: DMA holds lock against a continuously requesting core.
        drive(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        next_cycle();
        drive(1'b0, 2'b01, 2'b00, 2'b00, 16'h0400, 16'h0500, 16'h0, 16'h0);
        #3;
        check("burst_pre_gnt", 36'(bus.gnt), 36'(2'b01));
        next_cycle();
        bexp[0] = 2'b10; bexp[1] = 2'b10; bexp[2] = 2'b10;
        bexp[3] = 2'b10; bexp[4] = 2'b01; bexp[5] = 2'b10;
        prev_g = 2'b01;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 2'b11, 2'b00, 2'b10, 16'h0400, 16'h0500, 16'h0, 16'h0);
            er_v = (prev_g == 2'b01) ? {2'b01, 2'b00, ram_init(16'h0400)}
                                     : {2'b10, 2'b00, ram_init(16'h0500)};
            #3;
            check($sformatf("burst%0d_gnt", k), 36'(bus.gnt), 36'(bexp[k]));
            check($sformatf("burst%0d_resp", k), 36'(cur_resp()), 36'(er_v));
            next_cycle();
            prev_g = bexp[k];
        end
        // Owner drops req: lock is lost at once.
        drive(1'b0, 2'b01, 2'b00, 2'b00, 16'h0400, 16'h0500, 16'h0, 16'h0);
        #3;
        check("drop_gnt", 36'(bus.gnt), 36'(2'b01));
        next_cycle();
        drive(1'b0, 2'b11, 2'b00, 2'b00, 16'h0400, 16'h0500, 16'h0, 16'h0);
        #3;
        check("drop_next_gnt", 36'(bus.gnt), 36'(2'b10));
        next_cycle();

        // Reset in the middle of a locked write burst.
        drive(1'b0, 2'b10, 2'b10, 2'b10, 16'h0, 16'h0600, 16'h0, 16'hAAAA);
        #3;
        check("rburst0", {bus.gnt, mem_write}, {2'b10, 1'b1});
        next_cycle();
        drive(1'b0, 2'b10, 2'b10, 2'b10, 16'h0, 16'h0600, 16'h0, 16'hBBBB);
        #3;
        check("rburst1", {bus.gnt, mem_write}, {2'b10, 1'b1});
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'b10, 2'b10, 2'b10, 16'h0, 16'h0601, 16'h0, 16'hCCCC);
            #3;
            check($sformatf("in_rst%0d", k), {bus.gnt, mem_read, mem_write}, 4'b0000);
            next_cycle();
        end
        drive(1'b0, 2'b11, 2'b00, 2'b11, 16'h0700, 16'h0701, 16'h0, 16'h0);
        #3;
        check("post_rst_gnt", 36'(bus.gnt), 36'(2'b01));
        check("post_rst_resp", 36'({bus.rvalid, bus.err, bus.rdata}), 36'h0);
        next_cycle();
        check("rst_ram_0600", 36'(ram[16'h0600]), 36'(16'hBBBB));
        check("rst_ram_0601", 36'(ram[16'h0601]), 36'(ram_init(16'h0601)));

        // Read granted right before reset: its response is dropped.
        drive(1'b0, 2'b01, 2'b00, 2'b00, 16'h0100, 16'h0, 16'h0, 16'h0);
        #3;
        check("pre_rst_read_gnt", 36'(bus.gnt), 36'(2'b01));
        next_cycle();
        drive(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        #3;
        check("dropped_resp", 36'({bus.rvalid, bus.err, bus.rdata}), 36'h0);
        next_cycle();

        // Randomized run against the model.
        begin
            logic [35:0] eb;
            logic [W-1:0] nxt;
            logic [W-1:0] er;
            logic [1:0] held;
            logic [1:0] rq;
            logic [1:0] wv;
            logic [1:0] lk;
            word_t av [2];
            word_t dv [2];
            model_reset();
            exp_q.delete();
            exp_q.push_back('0);
            held = 2'b00;
            rq = 2'b00; wv = 2'b00; lk = 2'b00;
            av[0] = '0; av[1] = '0; dv[0] = '0; dv[1] = '0;
            for (int c = 0; c < N_RAND; c++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!held[i]) begin
                        int sel;
                        rq[i] = ($urandom_range(0, 3) != 0);
                        wv[i] = $urandom_range(0, 1) == 1;
                        sel = $urandom_range(0, 9);
                        case (sel)
                            0: av[i] = word_t'($urandom_range(0, 15));
                            1: av[i] = word_t'(16'h8000 + $urandom_range(0, 3));
                            2: av[i] = 16'h0010;
                            3: av[i] = 16'h7FFF;
                            default: av[i] = word_t'(16'h0100 + $urandom_range(0, 7));
                        endcase
                        dv[i] = word_t'($urandom);
                    end
                    lk[i] = ($urandom_range(0, 3) != 0);
                end
                drive((c == 0) || ($urandom_range(0, 59) == 0), rq, wv, lk,
                      av[0], av[1], dv[0], dv[1]);
                #3;
                er = exp_q.pop_front();
                model_step(eb, nxt);
                if (rst) er = '0;
                check($sformatf("rand%0d/bus", c), cur_bus(), eb);
                check($sformatf("rand%0d/resp", c), 36'(cur_resp()), 36'(mask_resp(er)));
                exp_q.push_back(nxt);
                held = rq & ~bus.gnt;
                next_cycle();
            end
        end
        drive(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        next_cycle();
        for (int a = 16'h0100; a < 16'h0108; a++)
            check($sformatf("ram_%h", a), 36'(ram[a]), 36'(model_read(a)));
        check("ram_0010", 36'(ram[16'h0010]), 36'(model_read(16'h0010)));
        check("ram_7fff", 36'(ram[16'h7FFF]), 36'(model_read(16'h7FFF)));
        for (int a = 0; a < 16; a++)
            check($sformatf("ram_low_%0d", a), 36'(ram[a]), 36'(ram_init(a)));
        for (int a = 16'h8000; a < 16'h8004; a++)
            check($sformatf("ram_hi_%h", a), 36'(ram[a]), 36'(ram_init(a)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
